alu_ctrl_issue: RTL and testbench
=================================

// Module: alu_ctrl_issue
// PURPOSE
//  Producer side of the 3-bit ALU_Control code consumed by the EX-stage ALU. Decodes ALUOp/funct7/funct3 into
//  the ALU op code, registers it as the ID/EX control stage with valid/ready handshakes, and stalls issue for
//  MUL_LAT cycles on MUL so the combinational multiplier path has time to settle.
// PARAMETERS
//  MUL_LAT   3   cycles from MUL accept to out_valid_o; legal range 1..15
// PORTS
//  clk_i          in   1  single clock, rising edge
//  rst_i          in   1  reset, synchronous, active-high
//  in_valid_i     in   1  decode request valid
//  in_ready_o     out  1  request accepted when in_valid_i & in_ready_o
//  ALUOp_i        in   2  00 ld/st, 01 branch, 10 R-type, 11 I-type ALU
//  funct7_i       in   7  instruction[31:25]
//  funct3_i       in   3  instruction[14:12]
//  out_valid_o    out  1  ALU_Control_o valid for EX
//  out_ready_i    in   1  EX consumes when out_valid_o & out_ready_i
//  ALU_Control_o  out  3  000 AND,001 XOR,010 SLL,011 ADD,100 SUB,101 MUL,110 SRAI,111 none
//  mul_busy_o     out  1  high while in MUL_WAIT
//  illegal_o      out  1  only with ALU_CTRL_ILLEGAL_TRAP_EN (see CONFIGURATION)
// BEHAVIOUR
//  Decode (comb): ALUOp 00->ADD; 01->SUB; 10: f7=0000000 f3 111->AND,100->XOR,001->SLL,000->ADD;
//   f7=0100000 f3 000->SUB; f7=0000001 f3 000->MUL; 11: f3 000->ADD (addi); f3 101 & f7 0100000->SRAI.
//   Any other combination is illegal -> code 111.
//  Reset: state EMPTY, out_valid_o=0, ALU_Control_o=000, mul_busy_o=0, counter=0, illegal_o=0.
//  FSM states EMPTY, FULL, MUL_WAIT (all outputs registered except in_ready_o):
//   EMPTY: in_ready_o=1. Accept non-MUL -> FULL next cycle (latency 1). Accept MUL -> MUL_WAIT,
//    cnt=MUL_LAT-1, ALU_Control_o=101; if MUL_LAT==1 go directly to FULL.
//   FULL: out_valid_o=1; in_ready_o=out_ready_i (drain and refill in the same cycle, no bubble).
//    out_ready_i=0: code and valid held stable, no accept. out_ready_i=1 & no input -> EMPTY.
//    out_ready_i=1 & input -> load as from EMPTY.
//   MUL_WAIT: in_ready_o=0, out_valid_o=0, mul_busy_o=1, code held 101; cnt decrements each cycle;
//    cnt==1 -> FULL next cycle. Net: MUL accepted at cycle T gives out_valid_o=1 at T+MUL_LAT.
//  Counter width $clog2(MUL_LAT+1); never wraps (loaded only on accept, stops at FULL).
//  rst_i mid-MUL_WAIT or FULL: pending op dropped, state returns to EMPTY next cycle, nothing issued.
//  in_valid_i while in_ready_o=0: ignored; upstream holds request stable (upstream's responsibility).
// CONFIGURATION
//  ALU_CTRL_ILLEGAL_TRAP_EN defined: an illegal decode is accepted but not issued (state stays or goes
//   EMPTY); illegal_o pulses 1 for exactly one cycle, the cycle after accept.
//  Not defined: no illegal_o port; an illegal decode issues normally as code 111 with latency 1
//   (ALU returns 0).
// STRUCTURE
//  Package alu_ctrl_pkg: ALU code localparams (ALU_AND..ALU_NONE), ALUOp encodings, funct7 constants
//   F7_BASE/F7_ALT/F7_MULDIV, FSM state typedef.
//  One sub-module: alu_ctrl_decode (pure comb decode -> code, is_mul, illegal); top holds FSM/counter/regs.
// TESTING
//  1 Reset held 2 cycles -> out_valid_o=0, ALU_Control_o=000, in_ready_o=1.
//  2 R-type f7=0100000 f3=000, out_ready_i=1 -> next cycle out_valid_o=1, code 100; 8 back-to-back
//    mixed non-MUL ops -> one issue per cycle, no bubbles.
//  3 MUL (f7=0000001 f3=000), MUL_LAT=3, accepted at T -> in_ready_o=0 T+1..T+2, mul_busy_o=1,
//    out_valid_o=1 code 101 at T+3.
//  4 FULL with code 001, out_ready_i=0 for 4 cycles -> code/valid stable, in_ready_o=0; release ->
//    new op accepted in the same cycle.
//  5 rst_i asserted at T+1 of a MUL_WAIT -> EMPTY, out_valid_o never rises for that MUL.
//  6 ALUOp=10 f7=0000000 f3=010 -> with macro: illegal_o one-cycle pulse, no out_valid_o;
//    without macro: out_valid_o=1, code 111.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes, ALUOp/funct7 encodings and issue FSM states
package alu_ctrl_pkg;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_SRAI = 3'b110;
  localparam logic [2:0] ALU_NONE = 3'b111;
  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_I    = 2'b11;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_MUL_WAIT} state_e;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALUOp/funct7/funct3 to ALU control code decode
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output logic [2:0] code_o,
  output logic       is_mul_o,
  output logic       illegal_o
);
  logic [2:0] r_code, i_code;
  always_comb begin
    r_code = funct7_i == F7_BASE ?
               (funct3_i == 3'b111 ? ALU_AND :
                funct3_i == 3'b100 ? ALU_XOR :
                funct3_i == 3'b001 ? ALU_SLL :
                funct3_i == 3'b000 ? ALU_ADD : ALU_NONE) :
             funct7_i == F7_ALT && funct3_i == 3'b000 ? ALU_SUB :
             funct7_i == F7_MULDIV && funct3_i == 3'b000 ? ALU_MUL : ALU_NONE;
    i_code = funct3_i == 3'b000 ? ALU_ADD :
             funct3_i == 3'b101 && funct7_i == F7_ALT ? ALU_SRAI : ALU_NONE;
    code_o = alu_op_i == ALUOP_LDST ? ALU_ADD :
             alu_op_i == ALUOP_BR   ? ALU_SUB :
             alu_op_i == ALUOP_R    ? r_code : i_code;
    is_mul_o  = code_o == ALU_MUL;
    illegal_o = code_o == ALU_NONE;
  end
endmodule

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: ALU control decode and ID/EX issue stage with MUL settle stall; ALU_CTRL_ILLEGAL_TRAP_EN traps illegal decodes
module alu_ctrl_issue
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [1:0] ALUOp_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [2:0] ALU_Control_o,
  output logic       mul_busy_o
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_o
`endif
);
  localparam int CW = $clog2(MUL_LAT + 1);
  state_e        state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dec_code;
  logic          dec_is_mul, dec_illegal, accept, drop;
  alu_ctrl_decode u_dec (
    .alu_op_i (ALUOp_i),
    .funct7_i (funct7_i),
    .funct3_i (funct3_i),
    .code_o   (dec_code),
    .is_mul_o (dec_is_mul),
    .illegal_o(dec_illegal)
  );
  assign in_ready_o    = state_q == ST_EMPTY || (state_q == ST_FULL && out_ready_i);
  assign accept        = in_valid_i && in_ready_o;
  assign out_valid_o   = state_q == ST_FULL;
  assign mul_busy_o    = state_q == ST_MUL_WAIT;
  assign ALU_Control_o = code_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign drop      = dec_illegal;
  assign illegal_o = illegal_q;
  always_comb illegal_d = accept && dec_illegal;
  always_ff @(posedge clk_i) illegal_q <= rst_i ? 1'b0 : illegal_d;
`else
  assign drop = 1'b0 & dec_illegal;
`endif
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    if (state_q == ST_MUL_WAIT) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? ST_FULL : ST_MUL_WAIT;
    end
    if (state_q == ST_FULL && out_ready_i) state_d = ST_EMPTY;
    if (accept && !drop) begin
      code_d  = dec_code;
      state_d = dec_is_mul && MUL_LAT > 1 ? ST_MUL_WAIT : ST_FULL;
      cnt_d   = dec_is_mul ? CW'(MUL_LAT - 1) : cnt_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      code_q  <= ALU_AND;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue: vector table, directed corner sequences and randomized model checking for alu_ctrl_issue
module tb_alu_ctrl_issue;
  localparam int MUL_LAT = 3;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, mul_busy;
  logic [1:0] alu_op;
  logic [6:0] f7;
  logic [2:0] f3, code;
  logic       ill;
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  alu_ctrl_issue #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .ALUOp_i      (alu_op),
    .funct7_i     (f7),
    .funct3_i     (f3),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .ALU_Control_o(code),
    .mul_busy_o   (mul_busy)
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_o    (ill)
`endif
  );
`ifndef ALU_CTRL_ILLEGAL_TRAP_EN
  assign ill = 1'b0;
`endif
  typedef struct {
    logic [1:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [2:0] code;
    int         lat;
  } vec_t;
  vec_t vt[10];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #3;
  endtask
  task automatic drv(input logic v, input logic [1:0] o, input logic [6:0] a, input logic [2:0] b, input logic r);
    in_valid  = v;
    alu_op    = o;
    f7        = a;
    f3        = b;
    out_ready = r;
  endtask
  function automatic logic [2:0] ref_decode(input logic [1:0] o, input logic [6:0] a, input logic [2:0] b);
    logic [11:0] k;
    k = {o, a, b};
    casez (k)
      12'b00_???????_???: return 3'd3;
      12'b01_???????_???: return 3'd4;
      12'b10_0000000_111: return 3'd0;
      12'b10_0000000_100: return 3'd1;
      12'b10_0000000_001: return 3'd2;
      12'b10_0000000_000: return 3'd3;
      12'b10_0100000_000: return 3'd4;
      12'b10_0000001_000: return 3'd5;
      12'b11_???????_000: return 3'd3;
      12'b11_0100000_101: return 3'd6;
      default:            return 3'd7;
    endcase
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    drv(1'b0, 2'b00, 7'd0, 3'd0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bit         m_has;
    logic [2:0] m_code, d;
    int         m_avail, m_ill_at, cyc;
    logic [2:0] b2b_f3[8];
    logic [6:0] b2b_f7[8];
    logic [2:0] b2b_code[8];
    vt[0] = '{2'b00, 7'h55, 3'b110, 3'd3, 1};
    vt[1] = '{2'b01, 7'h12, 3'b011, 3'd4, 1};
    vt[2] = '{2'b10, 7'h00, 3'b111, 3'd0, 1};
    vt[3] = '{2'b10, 7'h00, 3'b100, 3'd1, 1};
    vt[4] = '{2'b10, 7'h00, 3'b001, 3'd2, 1};
    vt[5] = '{2'b10, 7'h00, 3'b000, 3'd3, 1};
    vt[6] = '{2'b10, 7'h20, 3'b000, 3'd4, 1};
    vt[7] = '{2'b10, 7'h01, 3'b000, 3'd5, MUL_LAT};
    vt[8] = '{2'b11, 7'h7f, 3'b000, 3'd3, 1};
    vt[9] = '{2'b11, 7'h20, 3'b101, 3'd6, 1};
    rst = 1'b1;
    drv(1'b0, 2'b00, 7'd0, 3'd0, 1'b0);
    tick();
    tick();
    settle();
    chk("reset_valid", out_valid, 0);
    chk("reset_code", code, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_busy", mul_busy, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, vt[i].op, vt[i].f7, vt[i].f3, 1'b1);
      tick();
      drv(1'b0, 2'b00, 7'd0, 3'd0, 1'b1);
      for (int j = 1; j < vt[i].lat; j++) tick();
      settle();
      chk("vec_valid", out_valid, 1);
      chk("vec_code", code, vt[i].code);
      tick();
    end
    b2b_f7   = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
    b2b_f3   = '{3'b000, 3'b000, 3'b111, 3'b100, 3'b001, 3'b000, 3'b000, 3'b111};
    b2b_code = '{3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drv(1'b1, 2'b10, b2b_f7[i], b2b_f3[i], 1'b1);
      else drv(1'b0, 2'b00, 7'd0, 3'd0, 1'b1);
      settle();
      chk("b2b_ready", in_ready, 1);
      if (i > 0) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_code", code, b2b_code[i-1]);
      end
      tick();
    end
    drv(1'b1, 2'b10, 7'h01, 3'b000, 1'b1);
    tick();
    drv(1'b0, 2'b00, 7'd0, 3'd0, 1'b1);
    for (int j = 1; j < MUL_LAT; j++) begin
      settle();
      chk("mul_wait_ready", in_ready, 0);
      chk("mul_wait_busy", mul_busy, 1);
      chk("mul_wait_valid", out_valid, 0);
      tick();
    end
    settle();
    chk("mul_valid", out_valid, 1);
    chk("mul_code", code, 5);
    chk("mul_busy_off", mul_busy, 0);
    tick();
    drv(1'b1, 2'b10, 7'h00, 3'b100, 1'b1);
    tick();
    drv(1'b1, 2'b01, 7'h00, 3'b000, 1'b0);
    for (int j = 0; j < 4; j++) begin
      settle();
      chk("hold_valid", out_valid, 1);
      chk("hold_code", code, 1);
      chk("hold_ready", in_ready, 0);
      tick();
    end
    drv(1'b1, 2'b10, 7'h00, 3'b111, 1'b1);
    settle();
    chk("release_ready", in_ready, 1);
    tick();
    drv(1'b0, 2'b00, 7'd0, 3'd0, 1'b1);
    settle();
    chk("refill_valid", out_valid, 1);
    chk("refill_code", code, 0);
    tick();
    drv(1'b1, 2'b10, 7'h01, 3'b000, 1'b1);
    tick();
    drv(1'b0, 2'b00, 7'd0, 3'd0, 1'b1);
    rst = 1'b1;
    settle();
    chk("rst_mid_busy", mul_busy, 1);
    tick();
    rst = 1'b0;
    settle();
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_busy_off", mul_busy, 0);
    for (int j = 0; j < 5; j++) begin
      settle();
      chk("rst_mid_no_issue", out_valid, 0);
      tick();
    end
    drv(1'b1, 2'b10, 7'h00, 3'b010, 1'b1);
    tick();
    drv(1'b0, 2'b00, 7'd0, 3'd0, 1'b1);
    settle();
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    chk("illegal_pulse", ill, 1);
    chk("illegal_no_valid", out_valid, 0);
    tick();
    settle();
    chk("illegal_pulse_end", ill, 0);
    chk("illegal_still_empty", out_valid, 0);
`else
    chk("illegal_valid", out_valid, 1);
    chk("illegal_code", code, 7);
`endif
    tick();
    do_reset();
    m_has = 0;
    m_code = 3'd0;
    m_avail = 0;
    m_ill_at = -1;
    cyc = 0;
    for (int n = 0; n < 600; n++) begin
      bit ev, er, eb, acc;
      logic [6:0] rf7;
      case ($urandom_range(0, 3))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        2: rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      drv(1'($urandom_range(0, 3) != 0), 2'($urandom), rf7, 3'($urandom), 1'($urandom_range(0, 3) != 0));
      rst = $urandom_range(0, 49) == 0;
      settle();
      ev = m_has && cyc >= m_avail;
      eb = m_has && cyc < m_avail;
      er = !m_has || (ev && out_ready);
      chk("rnd_valid", out_valid, ev);
      chk("rnd_ready", in_ready, er);
      chk("rnd_busy", mul_busy, eb);
      if (ev) chk("rnd_code", code, m_code);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      chk("rnd_illegal", ill, cyc == m_ill_at);
`endif
      acc = in_valid && er;
      if (rst) begin
        m_has = 0;
        m_ill_at = -1;
      end else begin
        if (ev && out_ready) m_has = 0;
        if (acc) begin
          d = ref_decode(alu_op, f7, f3);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
          if (d == 3'd7) m_ill_at = cyc + 1;
          else begin
`else
          begin
`endif
            m_has = 1;
            m_code = d;
            m_avail = cyc + (d == 3'd5 ? MUL_LAT : 1);
          end
        end
      end
      cyc++;
      tick();
    end
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
